// File: rtl/alu_rs_scheduler.sv
// Reservation station for the shared ALU: holds renamed instructions, wakes operands from the
// CDB, issues the oldest ready entry and parks its result until the CDB arbiter grants it.
module alu_rs_scheduler #(
    parameter int SIZE  = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [2:0]                 alloc_op,
    input  logic [TAG_W-1:0]           alloc_tag,
    input  logic [31:0]                alloc_r1,
    input  logic [31:0]                alloc_r2,
    input  logic                       alloc_r1_rdy,
    input  logic                       alloc_r2_rdy,
    input  logic [TAG_W-1:0]           alloc_r1_tag,
    input  logic [TAG_W-1:0]           alloc_r2_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_W-1:0]           res_tag,
    output logic [31:0]                res_data,
    output logic [$clog2(SIZE+1)-1:0]  occupancy
);
    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE+1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;

    logic [SIZE-1:0]  valid, r1_rdy, r2_rdy, cand, pick;
    logic [SIZE-1:0]  older [SIZE];     // older[j][i]: entry j was allocated before entry i
    logic [2:0]       op_q     [SIZE];
    logic [TAG_W-1:0] dst_q    [SIZE];
    logic [TAG_W-1:0] r1_tag_q [SIZE];
    logic [TAG_W-1:0] r2_tag_q [SIZE];
    logic [31:0]      r1_q     [SIZE];
    logic [31:0]      r2_q     [SIZE];

    logic [IW-1:0] free_idx, issue_idx;
    logic          do_alloc, do_issue;
    logic          in_r1_rdy, in_r2_rdy;
    logic [31:0]   in_r1, in_r2;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
        case (op)
            OP_ADD:  alu = a + b;
            OP_SLL:  alu = a << sh;
            OP_SRA:  alu = 32'($signed(a) >>> sh);
            OP_SUB:  alu = a - b;
            OP_XOR:  alu = a ^ b;
            OP_SRL:  alu = a >> sh;
            OP_OR:   alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
    // res_tag/res_data hold steady while res_valid && !res_ready.
    assign alloc_ready = (occupancy < CW'(SIZE));
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign cand        = valid & r1_rdy & r2_rdy;
    assign do_issue    = (|cand) && (!res_valid || res_ready) && !flush;

    assign in_r1_rdy = alloc_r1_rdy || (cdb_valid && cdb_tag == alloc_r1_tag);
    assign in_r2_rdy = alloc_r2_rdy || (cdb_valid && cdb_tag == alloc_r2_tag);
    assign in_r1     = alloc_r1_rdy ? alloc_r1 : cdb_data;
    assign in_r2     = alloc_r2_rdy ? alloc_r2 : cdb_data;

    always_comb begin
        free_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (!valid[i]) free_idx = IW'(i);
    end

    // A candidate wins when no other candidate is older than it.
    always_comb begin
        pick      = '0;
        issue_idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            pick[i] = cand[i];
            for (int j = 0; j < SIZE; j++)
                if (cand[j] && older[j][i]) pick[i] = 1'b0;
        end
        for (int i = 0; i < SIZE; i++)
            if (pick[i]) issue_idx = IW'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= '0;
            r1_rdy    <= '0;
            r2_rdy    <= '0;
            for (int i = 0; i < SIZE; i++) older[i] <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
            occupancy <= '0;
        end else if (flush) begin
            valid     <= '0;
            for (int i = 0; i < SIZE; i++) older[i] <= '0;
            res_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (valid[i] && !r1_rdy[i] && cdb_valid && cdb_tag == r1_tag_q[i]) r1_rdy[i] <= 1'b1;
                if (valid[i] && !r2_rdy[i] && cdb_valid && cdb_tag == r2_tag_q[i]) r2_rdy[i] <= 1'b1;
            end
            if (do_issue) begin
                valid[issue_idx] <= 1'b0;
                for (int j = 0; j < SIZE; j++) older[j][issue_idx] <= 1'b0;
                res_valid <= 1'b1;
                res_tag   <= dst_q[issue_idx];
                res_data  <= alu(op_q[issue_idx], r1_q[issue_idx], r2_q[issue_idx],
                                 r2_q[issue_idx][4:0]);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (do_alloc) begin
                valid[free_idx]  <= 1'b1;
                r1_rdy[free_idx] <= in_r1_rdy;
                r2_rdy[free_idx] <= in_r2_rdy;
                older[free_idx]  <= '0;
                for (int j = 0; j < SIZE; j++)
                    if (IW'(j) != free_idx)
                        older[j][free_idx] <= valid[j] && !(do_issue && issue_idx == IW'(j));
            end
            if (do_alloc && !do_issue)      occupancy <= occupancy + CW'(1);
            else if (!do_alloc && do_issue) occupancy <= occupancy - CW'(1);
        end
    end

    // Payload needs no reset: it is only read while the matching valid/rdy bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (valid[i] && !r1_rdy[i] && cdb_valid && cdb_tag == r1_tag_q[i]) r1_q[i] <= cdb_data;
            if (valid[i] && !r2_rdy[i] && cdb_valid && cdb_tag == r2_tag_q[i]) r2_q[i] <= cdb_data;
        end
        if (do_alloc) begin
            op_q[free_idx]     <= alloc_op;
            dst_q[free_idx]    <= alloc_tag;
            r1_q[free_idx]     <= in_r1;
            r2_q[free_idx]     <= in_r2;
            r1_tag_q[free_idx] <= alloc_r1_tag;
            r2_tag_q[free_idx] <= alloc_r2_tag;
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: age-ordered queue model predicts issue results into a scoreboard;
// a monitor pops and compares on every result handshake.
module tb_alu_rs_scheduler;
    localparam int SIZE  = 8;
    localparam int TAG_W = 4;
    localparam int W     = TAG_W + 32;

    localparam logic [2:0] ADD = 3'd0, SLL = 3'd1, SRA = 3'd2, SUB = 3'd3;
    localparam logic [2:0] SRL = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0, alloc_valid = 1'b0, alloc_ready;
    logic [2:0] alloc_op = '0;
    logic [TAG_W-1:0] alloc_tag = '0, alloc_r1_tag = '0, alloc_r2_tag = '0;
    logic [31:0] alloc_r1 = '0, alloc_r2 = '0;
    logic alloc_r1_rdy = 1'b0, alloc_r2_rdy = 1'b0;
    logic cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic res_valid, res_ready = 1'b0;
    logic [TAG_W-1:0] res_tag;
    logic [31:0] res_data;
    logic [$clog2(SIZE+1)-1:0] occupancy;

    alu_rs_scheduler #(.SIZE(SIZE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
        .alloc_tag(alloc_tag), .alloc_r1(alloc_r1), .alloc_r2(alloc_r2),
        .alloc_r1_rdy(alloc_r1_rdy), .alloc_r2_rdy(alloc_r2_rdy),
        .alloc_r1_tag(alloc_r1_tag), .alloc_r2_tag(alloc_r2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_data(res_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      a, b;
        logic             ar, br;
        logic [TAG_W-1:0] at, bt;
    } ent_t;

    ent_t             model_q[$];      // index 0 is the oldest waiting instruction
    logic             m_rv = 1'b0;
    logic [W-1:0]     exp_q[$];
    logic [TAG_W-1:0] seen_q[$];
    logic [W-1:0]     mon_e;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] ones;
        s    = b[4:0];
        ones = 32'hFFFF_FFFF;
        case (op)
            3'd0: return a + b;
            3'd1: return a << s;
            3'd2: return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
            3'd3: return a - b;
            3'd4: return a ^ b;
            3'd5: return a >> s;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs currently driven.
    task automatic model_step();
        int   sel;
        ent_t e;
        logic do_issue, do_alloc;
        if (flush) begin
            model_q.delete();
            if (!res_ready) exp_q.delete();
            m_rv = 1'b0;
            return;
        end
        do_alloc = alloc_valid && (model_q.size() < SIZE);
        sel = -1;
        foreach (model_q[i])
            if (sel < 0 && model_q[i].ar && model_q[i].br) sel = i;
        do_issue = (sel >= 0) && (!m_rv || res_ready);
        if (do_issue) begin
            e = model_q[sel];
            exp_q.push_back({e.tag, ref_alu(e.op, e.a, e.b)});
            model_q.delete(sel);
            m_rv = 1'b1;
        end else if (res_ready) begin
            m_rv = 1'b0;
        end
        if (cdb_valid)
            foreach (model_q[i]) begin
                e = model_q[i];
                if (!e.ar && e.at == cdb_tag) begin e.a = cdb_data; e.ar = 1'b1; end
                if (!e.br && e.bt == cdb_tag) begin e.b = cdb_data; e.br = 1'b1; end
                model_q[i] = e;
            end
        if (do_alloc) begin
            e.op = alloc_op;   e.tag = alloc_tag;
            e.a  = alloc_r1;   e.ar  = alloc_r1_rdy; e.at = alloc_r1_tag;
            e.b  = alloc_r2;   e.br  = alloc_r2_rdy; e.bt = alloc_r2_tag;
            if (!e.ar && cdb_valid && e.at == cdb_tag) begin e.a = cdb_data; e.ar = 1'b1; end
            if (!e.br && cdb_valid && e.bt == cdb_tag) begin e.b = cdb_data; e.br = 1'b1; end
            model_q.push_back(e);
        end
    endtask

    // Called at posedge+1: check state, step the model, advance one cycle, clear pulses.
    task automatic tick();
        check("occupancy", 32'(occupancy), 32'(model_q.size()));
        check("alloc_ready", 32'(alloc_ready), 32'(model_q.size() < SIZE));
        check("res_valid", 32'(res_valid), 32'(m_rv));
        model_step();
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic alloc(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [31:0] a, input logic ar, input logic [TAG_W-1:0] at,
                         input logic [31:0] b, input logic br, input logic [TAG_W-1:0] bt);
        alloc_valid = 1'b1; alloc_op = op; alloc_tag = tag;
        alloc_r1 = a; alloc_r1_rdy = ar; alloc_r1_tag = at;
        alloc_r2 = b; alloc_r2_rdy = br; alloc_r2_tag = bt;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic wait_res(input string name, input logic [TAG_W-1:0] t, input logic [31:0] d);
        int k;
        k = 0;
        while (!res_valid && k < 20) begin tick(); k++; end
        check({name, "_valid"}, 32'(res_valid), 32'd1);
        check({name, "_tag"}, 32'(res_tag), 32'(t));
        check({name, "_data"}, res_data, d);
    endtask

    task automatic fill_ready(input int n);
        for (int k = 0; k < n; k++) begin
            alloc(ADD, TAG_W'(k), 32'(k * 3), 1'b1, '0, 32'd100, 1'b1, '0);
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got tag %h data %h, none expected", res_tag, res_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({res_tag, res_data} !== mon_e) begin
                    n_fail++;
                    $display("FAIL result: got tag %h data %h expected tag %h data %h",
                             res_tag, res_data, mon_e[W-1:32], mon_e[31:0]);
                end
            end
            seen_q.push_back(res_tag);
        end
    end

    initial begin
        #12;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        #5 rst = 1'b1;
        @(posedge clk); #1;

        // basic add: result visible two edges after allocation
        res_ready = 1'b1;
        alloc(ADD, 4'd3, 32'd5, 1'b1, '0, 32'd7, 1'b1, '0);
        tick(); tick();
        check("basic_valid", 32'(res_valid), 32'd1);
        check("basic_data", res_data, 32'd12);
        check("basic_tag", 32'(res_tag), 32'd3);
        tick(); tick();
        check("basic_occ", 32'(occupancy), 32'd0);

        // wakeup two cycles after allocation
        res_ready = 1'b0;
        alloc(SUB, 4'd5, 32'd10, 1'b1, '0, 32'd0, 1'b0, 4'd9);
        tick(); tick();
        cdb(4'd9, 32'd4);
        tick();
        wait_res("wakeup", 4'd5, 32'd6);
        res_ready = 1'b1; tick();

        // same-cycle CDB bypass into allocation
        res_ready = 1'b0;
        alloc(SUB, 4'd6, 32'd10, 1'b1, '0, 32'd0, 1'b0, 4'd9);
        cdb(4'd9, 32'd4);
        tick(); tick();
        check("bypass_valid", 32'(res_valid), 32'd1);
        check("bypass_data", res_data, 32'd6);
        res_ready = 1'b1; tick();

        // age order among candidates
        seen_q.delete();
        res_ready = 1'b0;
        alloc(ADD, 4'd1, 32'd1, 1'b0, 4'd9, 32'd2, 1'b1, '0); tick();
        alloc(ADD, 4'd2, 32'd3, 1'b1, '0, 32'd4, 1'b1, '0); tick();
        alloc(ADD, 4'd3, 32'd5, 1'b1, '0, 32'd6, 1'b1, '0); tick();
        res_ready = 1'b1;
        alloc(ADD, 4'd4, 32'd7, 1'b1, '0, 32'd8, 1'b1, '0);
        cdb(4'd9, 32'd100);
        tick();
        repeat (5) tick();
        check("age_count", 32'(seen_q.size()), 32'd4);
        if (seen_q.size() == 4) begin
            check("age_0", 32'(seen_q[0]), 32'd2);
            check("age_1", 32'(seen_q[1]), 32'd3);
            check("age_2", 32'(seen_q[2]), 32'd1);
            check("age_3", 32'(seen_q[3]), 32'd4);
        end

        // op coverage
        res_ready = 1'b0;
        alloc(SRA, 4'd10, 32'h8000_0000, 1'b1, '0, 32'd4, 1'b1, '0); tick();
        wait_res("sra", 4'd10, 32'hF800_0000); res_ready = 1'b1; tick(); res_ready = 1'b0;
        alloc(SRL, 4'd11, 32'h8000_0000, 1'b1, '0, 32'd4, 1'b1, '0); tick();
        wait_res("srl", 4'd11, 32'h0800_0000); res_ready = 1'b1; tick(); res_ready = 1'b0;
        alloc(SLL, 4'd12, 32'd1, 1'b1, '0, 32'h21, 1'b1, '0); tick();
        wait_res("sll", 4'd12, 32'd2); res_ready = 1'b1; tick(); res_ready = 1'b0;
        alloc(ADD, 4'd13, 32'hFFFF_FFFF, 1'b1, '0, 32'd1, 1'b1, '0); tick();
        wait_res("add_wrap", 4'd13, 32'd0); res_ready = 1'b1; tick();

        // backpressure and full
        res_ready = 1'b0;
        fill_ready(10);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        check("full_occ", 32'(occupancy), 32'd8);
        check("held_tag", 32'(res_tag), 32'd0);
        check("held_data", res_data, 32'd100);
        tick();
        check("held_tag2", 32'(res_tag), 32'd0);
        check("held_data2", res_data, 32'd100);
        seen_q.delete();
        res_ready = 1'b1;
        repeat (12) tick();
        check("drain_count", 32'(seen_q.size()), 32'd9);
        foreach (seen_q[i]) check("drain_order", 32'(seen_q[i]), 32'(i));

        // flush with entries and a held result
        res_ready = 1'b0;
        fill_ready(6);
        check("pre_flush_occ", 32'(occupancy), 32'd5);
        check("pre_flush_rv", 32'(res_valid), 32'd1);
        flush = 1'b1;
        alloc(ADD, 4'd7, 32'd1, 1'b1, '0, 32'd1, 1'b1, '0);
        tick();
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_rv", 32'(res_valid), 32'd0);
        check("flush_alloc_ready", 32'(alloc_ready), 32'd1);

        // asynchronous reset mid-cycle
        fill_ready(6);
        #2 rst = 1'b0;
        #1;
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_rv", 32'(res_valid), 32'd0);
        check("arst_alloc_ready", 32'(alloc_ready), 32'd1);
        model_q.delete();
        exp_q.delete();
        m_rv = 1'b0;
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 60)
                alloc(3'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 15)), $urandom,
                      $urandom_range(0, 3) != 0, TAG_W'($urandom_range(0, 7)),
                      $urandom, $urandom_range(0, 3) != 0, TAG_W'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) cdb(TAG_W'($urandom_range(0, 7)), $urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            tick();
        end

        // drain: broadcast every waiting tag
        res_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cdb(TAG_W'(c % 8), $urandom);
            tick();
        end
        tick();
        check("drain_empty_occ", 32'(occupancy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
